// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the 8-bit successive-approximation ADC controller.
package sar_adc_pkg;
    localparam int ADC_BITS              = 8;
    localparam int DEFAULT_SETTLE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

    function automatic logic [ADC_BITS-1:0] bit_mask(input logic [2:0] idx);
        logic [ADC_BITS-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: binary search over an 8-bit R-2R DAC driven by a synchronized comparator.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       comp_i,
    output logic [7:0] dac_o,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
);
    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    state_t                state, state_nxt;
    logic                  comp_s;
    logic [7:0]            cnt;
    logic [2:0]            idx;
    logic [ADC_BITS-1:0]   dac_q, result_q, decided;
    logic                  start_conv, decide;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (comp_i),
        .q   (comp_s)
    );

    // A new conversion begins from IDLE on start, or straight out of FINISH in continuous mode.
    assign start_conv = ((state == IDLE) && start) || ((state == FINISH) && continuous);
    assign decide     = (state == CONVERT) && (cnt == LAST_CNT);
    assign decided    = comp_s ? dac_q : (dac_q & ~bit_mask(idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (decide && (idx == 3'd0)) state_nxt = FINISH;
            FINISH:  state_nxt = continuous ? CONVERT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONVERT);
        done = (state == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_q    <= '0;
            result_q <= '0;
            idx      <= '0;
            cnt      <= '0;
        end else if (start_conv) begin
            dac_q <= 8'h80;
            idx   <= 3'd7;
            cnt   <= '0;
        end else if (decide) begin
            cnt <= '0;
            if (idx == 3'd0) begin
                dac_q    <= decided;
                result_q <= decided;
            end else begin
                dac_q <= decided | bit_mask(idx - 3'd1);
                idx   <= idx - 3'd1;
            end
        end else if (state == CONVERT) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign dac_o  = dac_q;
    assign result = result_q;
endmodule
